// File: rtl/mc14500b_seq.sv
// Program sequencer for the mc14500b ICU: PC, synchronous-read ROM port and a
// hardware return stack, redirected by the ICU's JMP / RTN / FLGO strobes.
module mc14500b_seq #(
    parameter int AW          = 8,
    parameter int IOW         = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    output logic [AW-1:0]                      o_rom_addr,
    input  logic [IOW+3:0]                     i_rom_data,
    output logic [3:0]                         o_op,
    output logic [IOW-1:0]                     o_io_addr,
    output logic                               o_valid,
    output logic [AW-1:0]                      o_pc,
    input  logic                               i_jmp,
    input  logic                               i_rtn,
    input  logic                               i_flgo,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   o_sp,
    output logic                               o_stk_err
);

    localparam int SPW  = $clog2(STACK_DEPTH + 1);
    localparam int IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [3:0] OP_NOPF = 4'hF;

    logic [AW-1:0]   rom_addr;
    logic [AW-1:0]   pc;
    logic            valid;
    logic [SPW-1:0]  sp;
    logic            stk_err;
    logic [AW-1:0]   stack [STACK_DEPTH];

    logic            do_rtn;
    logic            do_jmp;
    logic            do_call;
    logic            pop_ok;
    logic            push_ok;
    logic            redirect;
    logic [SPW-1:0]  sp_m1;
    logic [IDXW-1:0] push_idx;
    logic [IDXW-1:0] pop_idx;
    logic [AW-1:0]   target;
    logic [AW-1:0]   ret_addr;

    // A bubble presents NOPF with a zero operand so downstream logic sees no effect.
    always_comb begin
        o_op      = valid ? i_rom_data[3:0] : OP_NOPF;
        o_io_addr = valid ? i_rom_data[IOW+3:4] : '0;
    end

    // NOTE: every signal gets an unconditional assignment at the top of the
    // block, so no path leaves a value held and no latch is inferred.
    always_comb begin
        do_rtn   = valid & i_rtn;
        do_jmp   = valid & i_jmp & ~i_rtn;
        do_call  = valid & i_flgo & ~i_rtn & ~i_jmp;
        pop_ok   = do_rtn && (sp != '0);
        push_ok  = do_call && (sp != SPW'(STACK_DEPTH));
        redirect = pop_ok | do_jmp | do_call;
        sp_m1    = sp - SPW'(1);
        push_idx = sp[IDXW-1:0];
        pop_idx  = sp_m1[IDXW-1:0];
        ret_addr = pc + AW'(1);
        target   = o_io_addr[AW-1:0];
        if (pop_ok) begin
            target = stack[pop_idx];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rom_addr <= '0;
            pc       <= '0;
            valid    <= 1'b0;
            sp       <= '0;
            stk_err  <= 1'b0;
        end else begin
            pc <= rom_addr;
            // A redirect discards the word already in flight from the ROM.
            if (redirect) begin
                rom_addr <= target;
                valid    <= 1'b0;
            end else begin
                rom_addr <= rom_addr + AW'(1);
                valid    <= 1'b1;
            end
            if (pop_ok) begin
                sp <= sp_m1;
            end else if (push_ok) begin
                sp <= sp + SPW'(1);
            end
            if ((do_rtn && !pop_ok) || (do_call && !push_ok)) begin
                stk_err <= 1'b1;
            end
        end
    end

    // NOTE: the stack array is deliberately not reset; clearing sp makes every
    // entry unreachable, and leaving the array out of reset keeps it plain storage.
    always_ff @(posedge i_clk) begin
        if (!i_rst && push_ok) begin
            stack[push_idx] <= ret_addr;
        end
    end

    assign o_rom_addr = rom_addr;
    assign o_pc       = pc;
    assign o_valid    = valid;
    assign o_sp       = sp;
    assign o_stk_err  = stk_err;

endmodule
